// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array result path.
package sa_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } stream_state_t;

   // Width of a row/column index for an n x n matrix, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sa_requant.sv
// Combinational requantiser: arithmetic right shift at accumulator width,
// then signed saturation to the narrower output width.
module sa_requant #(
   parameter int ACC   = 32,
   parameter int OUT_W = 16,
   parameter int SHIFT = 0
) (
   input  logic signed [ACC-1:0]   acc,
   output logic signed [OUT_W-1:0] data,
   output logic                    sat
);

   localparam logic signed [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

   logic signed [ACC-1:0] shifted;
   logic [ACC-OUT_W:0]    upper;
   logic                  pos_ovf;
   logic                  neg_ovf;

   assign shifted = acc >>> SHIFT;

   // The value fits iff every bit from the output sign bit upward equals the sign.
   assign upper   = shifted[ACC-1:OUT_W-1];
   assign pos_ovf = !shifted[ACC-1] && (|upper);
   assign neg_ovf =  shifted[ACC-1] && !(&upper);

   always_comb begin
      data = shifted[OUT_W-1:0];
      sat  = 1'b0;
      if (pos_ovf) begin
         data = MAX_V;
         sat  = 1'b1;
      end else if (neg_ovf) begin
         data = MIN_V;
         sat  = 1'b1;
      end
   end

endmodule

// File: rtl/sa_result_streamer.sv
// Snapshots the N x N accumulator matrix on capture and streams it row-major,
// one requantised element per valid/ready beat.
module sa_result_streamer
   import sa_pkg::*;
#(
   parameter int ACC   = 32,
   parameter int N     = 3,
   parameter int OUT_W = 16,
   parameter int SHIFT = 0,
   localparam int IDXW = idx_width(N)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [ACC-1:0]   c_in [N][N],
   input  logic                    c_valid,
   output logic                    c_ready,
   output logic signed [OUT_W-1:0] m_data,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic                    m_last,
   output logic [IDXW-1:0]         m_row,
   output logic [IDXW-1:0]         m_col,
   output logic                    m_sat,
   output logic                    busy,
   output logic                    err_drop
);

   localparam logic [IDXW-1:0] IDX_MAX = IDXW'(N - 1);

   stream_state_t         state_reg, state_next;
   logic [IDXW-1:0]       row_reg, row_next;
   logic [IDXW-1:0]       col_reg, col_next;
   logic                  err_drop_reg;
   logic signed [ACC-1:0] buf_reg [N][N];
   logic signed [ACC-1:0] sel_elem;

   logic capture;
   logic handshake;
   logic col_end;
   logic at_last;

   assign col_end   = (col_reg == IDX_MAX);
   assign at_last   = (row_reg == IDX_MAX) && col_end;
   assign m_valid   = (state_reg == STREAM);
   assign busy      = (state_reg == STREAM);
   assign m_last    = m_valid && at_last;
   assign handshake = m_valid && m_ready;

   // Ready also during the final handshake so matrices can be streamed back to back.
   assign c_ready   = (state_reg == IDLE) || (handshake && at_last);
   assign capture   = c_valid && c_ready;

   assign m_row     = row_reg;
   assign m_col     = col_reg;
   assign err_drop  = err_drop_reg;

   always_comb begin
      state_next = state_reg;
      row_next   = row_reg;
      col_next   = col_reg;
      if (capture) begin
         state_next = STREAM;
         row_next   = '0;
         col_next   = '0;
      end else if (handshake) begin
         if (at_last) begin
            state_next = IDLE;
            row_next   = '0;
            col_next   = '0;
         end else if (col_end) begin
            col_next = '0;
            row_next = row_reg + 1'b1;
         end else begin
            col_next = col_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         row_reg      <= '0;
         col_reg      <= '0;
         err_drop_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         row_reg      <= row_next;
         col_reg      <= col_next;
         err_drop_reg <= err_drop_reg || (c_valid && !c_ready);
      end
   end

   // Snapshot buffer is deliberately left out of reset; it is only read while streaming.
   always_ff @(posedge clk) begin
      if (capture) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               buf_reg[i][j] <= c_in[i][j];
            end
         end
      end
   end

   assign sel_elem = buf_reg[row_reg][col_reg];

   sa_requant #(
      .ACC   (ACC),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
   ) u_requant (
      .acc  (sel_elem),
      .data (m_data),
      .sat  (m_sat)
   );

endmodule

// File: tb/tb_sa_result_streamer.sv
// Directed bench for sa_result_streamer (N=3, ACC=32, OUT_W=16; second instance with SHIFT=4).
module tb_sa_result_streamer;

   logic               clk;
   logic               rst;
   logic signed [31:0] c_in [3][3];
   logic               c_valid;
   logic               c_ready;
   logic signed [15:0] m_data;
   logic               m_valid;
   logic               m_ready;
   logic               m_last;
   logic [1:0]         m_row;
   logic [1:0]         m_col;
   logic               m_sat;
   logic               busy;
   logic               err_drop;

   logic signed [31:0] c_in_s [3][3];
   logic               c_valid_s;
   logic               c_ready_s;
   logic signed [15:0] m_data_s;
   logic               m_valid_s;
   logic               m_ready_s;
   logic               m_last_s;
   logic [1:0]         m_row_s;
   logic [1:0]         m_col_s;
   logic               m_sat_s;
   logic               busy_s;
   logic               err_drop_s;

   int checks = 0;
   int errors = 0;
   int exp_d [9];
   bit exp_s [9];

   sa_result_streamer #(.ACC(32), .N(3), .OUT_W(16), .SHIFT(0)) dut (
      .clk(clk), .rst(rst), .c_in(c_in), .c_valid(c_valid), .c_ready(c_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
      .m_row(m_row), .m_col(m_col), .m_sat(m_sat), .busy(busy), .err_drop(err_drop)
   );

   sa_result_streamer #(.ACC(32), .N(3), .OUT_W(16), .SHIFT(4)) dut_shift (
      .clk(clk), .rst(rst), .c_in(c_in_s), .c_valid(c_valid_s), .c_ready(c_ready_s),
      .m_data(m_data_s), .m_valid(m_valid_s), .m_ready(m_ready_s), .m_last(m_last_s),
      .m_row(m_row_s), .m_col(m_col_s), .m_sat(m_sat_s), .busy(busy_s),
      .err_drop(err_drop_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Matrix base, base+1, ... row-major; expected beats are the same values unsaturated.
   task automatic load_mat(input int base);
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            c_in[i][j]     = base + i * 3 + j;
            exp_d[i*3 + j] = base + i * 3 + j;
            exp_s[i*3 + j] = 1'b0;
         end
      end
   endtask

   task automatic capture(input string t);
      c_valid = 1'b1;
      check({t, " c_ready at capture"}, c_ready, 1);
      @(negedge clk);
      c_valid = 1'b0;
   endtask

   task automatic check_beat(input string t, input int k);
      check($sformatf("%s m_valid b%0d", t, k), m_valid, 1);
      check($sformatf("%s data b%0d", t, k), m_data, exp_d[k]);
      check($sformatf("%s sat b%0d", t, k), m_sat, exp_s[k]);
      check($sformatf("%s row b%0d", t, k), m_row, k / 3);
      check($sformatf("%s col b%0d", t, k), m_col, k % 3);
      check($sformatf("%s last b%0d", t, k), m_last, (k == 8) ? 1 : 0);
      check($sformatf("%s busy b%0d", t, k), busy, 1);
   endtask

   // Leaves the bench at the negedge after the handshake of beat 'last_k'.
   task automatic run_beats(input string t, input int first_k, input int last_k, input bit stall);
      for (int k = first_k; k <= last_k; k++) begin
         if (stall) begin
            m_ready = 1'b0;
            check_beat({t, " pre"}, k);
            @(negedge clk);
            check_beat({t, " held"}, k);
         end
         m_ready = 1'b1;
         check_beat(t, k);
         $display("%s beat %0d row %0d col %0d data %0d sat %0d", t, k, m_row, m_col, m_data, m_sat);
         @(negedge clk);
      end
   endtask

   task automatic check_idle(input string t);
      check({t, " m_valid idle"}, m_valid, 0);
      check({t, " busy idle"}, busy, 0);
      check({t, " c_ready idle"}, c_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within bound");
      $fatal(1, "timeout");
   end

   initial begin
      rst       = 1'b1;
      c_valid   = 1'b0;
      m_ready   = 1'b0;
      c_valid_s = 1'b0;
      m_ready_s = 1'b1;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            c_in[i][j]   = '0;
            c_in_s[i][j] = '0;
         end
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_idle("reset");
      check("reset err_drop", err_drop, 0);
      check("reset row", m_row, 0);
      check("reset col", m_col, 0);

      // 1: plain stream at full rate
      load_mat(1);
      capture("t1");
      run_beats("t1", 0, 8, 1'b0);
      check_idle("t1");

      // 2: alternating back-pressure
      load_mat(1);
      capture("t2");
      run_beats("t2", 0, 8, 1'b1);
      check_idle("t2");

      // 3: saturation both directions
      load_mat(0);
      c_in[0][0] = 40000;
      c_in[0][1] = -40000;
      c_in[0][2] = 123;
      exp_d[0] = 32767;  exp_s[0] = 1'b1;
      exp_d[1] = -32768; exp_s[1] = 1'b1;
      exp_d[2] = 123;    exp_s[2] = 1'b0;
      capture("t3");
      run_beats("t3", 0, 8, 1'b0);
      check_idle("t3");

      // 3b: SHIFT=4 instance
      c_in_s[0][0] = 32'h0000_0100;
      c_in_s[0][1] = -17;
      c_in_s[0][2] = 32'h7fff_ffff;
      c_valid_s = 1'b1;
      @(negedge clk);
      c_valid_s = 1'b0;
      check("t3s data 0x100", m_data_s, 16);
      check("t3s sat 0x100", m_sat_s, 0);
      $display("t3s beat 0 data %0d sat %0d", m_data_s, m_sat_s);
      @(negedge clk);
      check("t3s data -17", m_data_s, -2);
      check("t3s sat -17", m_sat_s, 0);
      $display("t3s beat 1 data %0d sat %0d", m_data_s, m_sat_s);
      @(negedge clk);
      check("t3s data max", m_data_s, 32767);
      check("t3s sat max", m_sat_s, 1);
      $display("t3s beat 2 data %0d sat %0d", m_data_s, m_sat_s);

      // 4: capture attempt mid-stream is dropped
      load_mat(1);
      capture("t4");
      check("t4 err_drop before", err_drop, 0);
      run_beats("t4", 0, 1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            c_in[i][j] = 100 + i * 3 + j;
         end
      end
      c_valid = 1'b1;
      check("t4 c_ready mid", c_ready, 0);
      run_beats("t4", 2, 2, 1'b0);
      c_valid = 1'b0;
      check("t4 err_drop after", err_drop, 1);
      run_beats("t4", 3, 8, 1'b0);
      check_idle("t4");
      check("t4 err_drop sticky", err_drop, 1);

      // 5: back-to-back capture on the last handshake
      load_mat(1);
      capture("t5");
      run_beats("t5a", 0, 7, 1'b0);
      m_ready = 1'b1;
      check_beat("t5a", 8);
      load_mat(11);
      c_valid = 1'b1;
      check("t5 c_ready on last", c_ready, 1);
      @(negedge clk);
      c_valid = 1'b0;
      run_beats("t5b", 0, 8, 1'b0);
      check_idle("t5");

      // 6: reset mid-stream, then a fresh capture
      load_mat(21);
      capture("t6");
      run_beats("t6a", 0, 3, 1'b0);
      m_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle("t6 rst");
      check("t6 err_drop", err_drop, 0);
      check("t6 row", m_row, 0);
      check("t6 col", m_col, 0);
      load_mat(31);
      capture("t6");
      run_beats("t6b", 0, 8, 1'b0);
      check_idle("t6 end");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
